pp_loop_status_monitor: RTL and testbench

Synthesizable activity monitor for one HLS-generated pipelined loop and one block-level `ap_*` handshake. It decodes the host block's one-hot FSM state against the supplied loop-boundary state codes, tracks loop invocations, iteration starts and ends, and stall cycles, and counts module start, ready and done events. It sits beside the HLS core in the simulation/debug wrapper and exposes saturating counters. Counters freeze when `finish` is asserted.

---
 rtl/pp_loop_mon_pkg.sv | 13 +
 rtl/pp_loop_status_monitor_sat_counter.sv | 23 ++
 rtl/pp_loop_status_monitor.sv | 160 ++++++++++++++++
 tb/tb_pp_loop_status_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pp_loop_mon_pkg.sv
// Shared types for the pipelined-loop status monitor.
// Loop tracker states and the default counter width.
package pp_loop_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2
  } loop_state_e;

  localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pp_loop_status_monitor_sat_counter.sv
// Saturating up-counter with freeze input.
// Stops at all-ones instead of wrapping; hold blocks every update
// except the synchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  output logic [CNT_W-1:0] q
);

  // count up on en, stick at all-ones, frozen by hold
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (en && !hold && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pp_loop_status_monitor.sv
// Activity monitor for one HLS pipelined loop and one ap_* handshake.
// Optional macro PP_LOOP_MON_STALL_EN: when defined, stall_cycles is a
// real counter; otherwise it is tied to zero.
//
// state | meaning
// IDLE  | host FSM outside the loop
// PRE   | host FSM in the pre-loop state, loop about to start
// RUN   | loop body executing (host parked in the loop quit state)
module pp_loop_status_monitor
  import pp_loop_mon_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state0,
  input  logic [STATE_W-1:0] post_loop_state0,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] loop_quit_state,
  input  logic               pre_states_valid,
  input  logic               post_states_valid,
  input  logic               iter_start_enable,
  input  logic               iter_start_block,
  input  logic               iter_end_enable,
  input  logic               iter_end_block,
  input  logic               quit_at_end,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               finish,
  output logic [1:0]         loop_state,
  output logic [CNT_W-1:0]   loop_invocations,
  output logic [CNT_W-1:0]   iter_started,
  output logic [CNT_W-1:0]   iter_ended,
  output logic [CNT_W-1:0]   loop_cycles,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_starts,
  output logic [CNT_W-1:0]   mod_readies,
  output logic [CNT_W-1:0]   mod_dones,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic               loop_err,
  output logic               frozen
);

  loop_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             err_q, frozen_q;
  logic             pre_match, post_match, iter_match, end_match;
  logic             entry, run_exit, in_run;
  logic             start_ev, end_ev, err_set;
  logic [CNT_W-1:0] started_nxt, ended_nxt;

  assign pre_match  = pre_states_valid  && (cur_state == pre_loop_state0);
  assign post_match = post_states_valid && (cur_state == post_loop_state0);
  assign iter_match = (cur_state == iter_start_state);
  assign end_match  = (cur_state == iter_end_state);
  assign in_run     = (state_q == RUN);

  // loop tracker next state plus entry/exit strobes
  always_comb begin
    state_d  = state_q;
    entry    = 1'b0;
    run_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (iter_match) begin
          state_d = RUN;
          entry   = 1'b1;
        end else if (pre_match) begin
          state_d = PRE;
        end
      end
      PRE: begin
        if (iter_match) begin
          state_d = RUN;
          entry   = 1'b1;
        end else if (!pre_match) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if ((cur_state != loop_quit_state) || post_match) begin
          state_d  = IDLE;
          run_exit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ev = iter_match && iter_start_enable && !iter_start_block && (in_run || entry);
  assign end_ev   = end_match && iter_end_enable && !iter_end_block;

  // the balance check must include an event landing on the exit cycle,
  // so compare the counts as they will be after this edge
  assign started_nxt = (start_ev && (iter_started != {CNT_W{1'b1}})) ? iter_started + CNT_W'(1) : iter_started;
  assign ended_nxt   = (end_ev && (iter_ended != {CNT_W{1'b1}})) ? iter_ended + CNT_W'(1) : iter_ended;
  assign err_set     = run_exit && quit_at_end && (started_nxt != ended_nxt);

  // busy flag: done&continue wins over a same-cycle start
  always_comb begin
    busy_d = busy_q;
    if (ap_done && ap_continue) begin
      busy_d = 1'b0;
    end else if (ap_start) begin
      busy_d = 1'b1;
    end
  end

  // state and flag registers, all held once frozen
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      frozen_q <= 1'b0;
    end else if (!frozen_q) begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (err_set) err_q <= 1'b1;
      if (finish) frozen_q <= 1'b1;
    end
  end

  assign loop_state = state_q;
  assign mod_busy   = busy_q;
  assign loop_err   = err_q;
  assign frozen     = frozen_q;

  sat_counter #(.CNT_W(CNT_W)) u_invocations (
    .clock(clock), .reset(reset), .en(entry), .hold(frozen_q), .q(loop_invocations));
  sat_counter #(.CNT_W(CNT_W)) u_started (
    .clock(clock), .reset(reset), .en(start_ev), .hold(frozen_q), .q(iter_started));
  sat_counter #(.CNT_W(CNT_W)) u_ended (
    .clock(clock), .reset(reset), .en(end_ev), .hold(frozen_q), .q(iter_ended));
  sat_counter #(.CNT_W(CNT_W)) u_loop_cycles (
    .clock(clock), .reset(reset), .en(in_run), .hold(frozen_q), .q(loop_cycles));
  sat_counter #(.CNT_W(CNT_W)) u_mod_starts (
    .clock(clock), .reset(reset), .en(ap_start && ap_ready), .hold(frozen_q), .q(mod_starts));
  sat_counter #(.CNT_W(CNT_W)) u_mod_readies (
    .clock(clock), .reset(reset), .en(ap_ready), .hold(frozen_q), .q(mod_readies));
  sat_counter #(.CNT_W(CNT_W)) u_mod_dones (
    .clock(clock), .reset(reset), .en(ap_done && ap_continue), .hold(frozen_q), .q(mod_dones));
  sat_counter #(.CNT_W(CNT_W)) u_busy_cycles (
    .clock(clock), .reset(reset), .en(busy_q), .hold(frozen_q), .q(mod_busy_cycles));

`ifdef PP_LOOP_MON_STALL_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clock(clock), .reset(reset), .en(in_run && (iter_start_block || iter_end_block)),
    .hold(frozen_q), .q(stall_cycles));
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pp_loop_status_monitor.sv
// Directed bench for pp_loop_status_monitor. A second instance with
// 4-bit counters shares the stimulus and covers saturation.
module tb_pp_loop_status_monitor;

  localparam logic [4:0] C_PRE  = 5'b00001;
  localparam logic [4:0] C_ITER = 5'b00010;
  localparam logic [4:0] C_OTH  = 5'b00100;
  localparam logic [4:0] C_POST = 5'b10000;
`ifdef PP_LOOP_MON_STALL_EN
  localparam logic [31:0] EXP_STALL = 32'd2;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  cur_state;
  logic        iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;
  logic        quit_at_end, ap_start, ap_ready, ap_done, ap_continue, finish;

  logic [1:0]  loop_state, s_loop_state;
  logic [31:0] loop_invocations, iter_started, iter_ended, loop_cycles, stall_cycles;
  logic [31:0] mod_starts, mod_readies, mod_dones, mod_busy_cycles;
  logic        mod_busy, loop_err, frozen;
  logic [3:0]  s_invocations, s_started, s_ended, s_loop_cycles, s_stall;
  logic [3:0]  s_starts, s_readies, s_dones, s_busy_cycles;
  logic        s_busy, s_err, s_frozen;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pp_loop_status_monitor dut (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .pre_loop_state0(C_PRE), .post_loop_state0(C_POST),
    .iter_start_state(C_ITER), .iter_end_state(C_ITER), .loop_quit_state(C_ITER),
    .pre_states_valid(1'b1), .post_states_valid(1'b1),
    .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .quit_at_end(quit_at_end), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .loop_state(loop_state), .loop_invocations(loop_invocations),
    .iter_started(iter_started), .iter_ended(iter_ended),
    .loop_cycles(loop_cycles), .stall_cycles(stall_cycles), .mod_busy(mod_busy),
    .mod_starts(mod_starts), .mod_readies(mod_readies), .mod_dones(mod_dones),
    .mod_busy_cycles(mod_busy_cycles), .loop_err(loop_err), .frozen(frozen));

  pp_loop_status_monitor #(.STATE_W(5), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .pre_loop_state0(C_PRE), .post_loop_state0(C_POST),
    .iter_start_state(C_ITER), .iter_end_state(C_ITER), .loop_quit_state(C_ITER),
    .pre_states_valid(1'b1), .post_states_valid(1'b1),
    .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .quit_at_end(quit_at_end), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .loop_state(s_loop_state), .loop_invocations(s_invocations),
    .iter_started(s_started), .iter_ended(s_ended),
    .loop_cycles(s_loop_cycles), .stall_cycles(s_stall), .mod_busy(s_busy),
    .mod_starts(s_starts), .mod_readies(s_readies), .mod_dones(s_dones),
    .mod_busy_cycles(s_busy_cycles), .loop_err(s_err), .frozen(s_frozen));

  // one rising edge, then settle before sampling
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    cur_state = C_OTH;
    iter_start_enable = 1'b1; iter_start_block = 1'b0;
    iter_end_enable = 1'b1;   iter_end_block = 1'b0;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
    finish = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    quit_at_end = 1'b0;
    pulse_reset();
    checks++; if (loop_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", loop_state); end
    checks++; if (loop_invocations !== 0 || iter_started !== 0 || iter_ended !== 0 || loop_cycles !== 0 || stall_cycles !== 0)
      begin failures++; $display("FAIL reset_loop_cnt got=%0d/%0d/%0d/%0d/%0d exp=0", loop_invocations, iter_started, iter_ended, loop_cycles, stall_cycles); end
    checks++; if (mod_starts !== 0 || mod_readies !== 0 || mod_dones !== 0 || mod_busy_cycles !== 0)
      begin failures++; $display("FAIL reset_mod_cnt got=%0d/%0d/%0d/%0d exp=0", mod_starts, mod_readies, mod_dones, mod_busy_cycles); end
    checks++; if ({mod_busy, loop_err, frozen} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {mod_busy, loop_err, frozen}); end
  endtask

  task automatic test_basic_loop();
    quit_at_end = 1'b1;
    pulse_reset();
    cur_state = C_PRE; cyc();
    checks++; if (loop_state !== 2'd1) begin failures++; $display("FAIL basic_pre got=%0d exp=1", loop_state); end
    cur_state = C_ITER; cyc();
    checks++; if (loop_state !== 2'd2) begin failures++; $display("FAIL basic_run got=%0d exp=2", loop_state); end
    cyc(3);
    cur_state = C_POST; cyc();
    cur_state = C_OTH;
    checks++; if (loop_invocations !== 32'd1) begin failures++; $display("FAIL basic_inv got=%0d exp=1", loop_invocations); end
    checks++; if (iter_started !== 32'd4) begin failures++; $display("FAIL basic_started got=%0d exp=4", iter_started); end
    checks++; if (iter_ended !== 32'd4) begin failures++; $display("FAIL basic_ended got=%0d exp=4", iter_ended); end
    checks++; if (loop_cycles !== 32'd4) begin failures++; $display("FAIL basic_cycles got=%0d exp=4", loop_cycles); end
    checks++; if (loop_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", loop_err); end
    checks++; if (loop_state !== 2'd0) begin failures++; $display("FAIL basic_idle got=%0d exp=0", loop_state); end
  endtask

  task automatic test_stall();
    quit_at_end = 1'b0;
    pulse_reset();
    cur_state = C_PRE; cyc();
    cur_state = C_ITER;
    for (int i = 0; i < 6; i++) begin
      iter_start_block = (i == 2 || i == 3);
      cyc();
    end
    iter_start_block = 1'b0;
    cur_state = C_POST; cyc();
    cur_state = C_OTH;
    checks++; if (stall_cycles !== EXP_STALL) begin failures++; $display("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, EXP_STALL); end
    checks++; if (iter_started !== 32'd4) begin failures++; $display("FAIL stall_started got=%0d exp=4", iter_started); end
    checks++; if (iter_ended !== 32'd6) begin failures++; $display("FAIL stall_ended got=%0d exp=6", iter_ended); end
    checks++; if (loop_cycles !== 32'd6) begin failures++; $display("FAIL stall_loop_cycles got=%0d exp=6", loop_cycles); end
  endtask

  task automatic test_loop_err();
    for (int q = 1; q >= 0; q--) begin
      quit_at_end = (q == 1);
      pulse_reset();
      cur_state = C_PRE; cyc();
      cur_state = C_ITER;
      for (int i = 0; i < 3; i++) begin
        iter_end_block = (i == 1);
        cyc();
      end
      iter_end_block = 1'b0;
      cur_state = C_POST; cyc();
      cur_state = C_OTH; cyc();
      checks++; if (iter_started !== 32'd3 || iter_ended !== 32'd2)
        begin failures++; $display("FAIL err_counts q=%0d got=%0d/%0d exp=3/2", q, iter_started, iter_ended); end
      checks++; if (loop_err !== quit_at_end)
        begin failures++; $display("FAIL loop_err q=%0d got=%b exp=%b", q, loop_err, quit_at_end); end
    end
  endtask

  task automatic test_handshake();
    pulse_reset();
    ap_start = 1'b1; ap_ready = 1'b1; cyc();
    ap_start = 1'b0; ap_ready = 1'b0;
    checks++; if (mod_busy !== 1'b1) begin failures++; $display("FAIL hs_busy_set got=%b exp=1", mod_busy); end
    checks++; if (mod_starts !== 32'd1 || mod_readies !== 32'd1)
      begin failures++; $display("FAIL hs_start_ready got=%0d/%0d exp=1/1", mod_starts, mod_readies); end
    cyc(4);
    ap_done = 1'b1; ap_continue = 1'b1; cyc();
    ap_done = 1'b0; ap_continue = 1'b0;
    checks++; if (mod_dones !== 32'd1) begin failures++; $display("FAIL hs_dones got=%0d exp=1", mod_dones); end
    checks++; if (mod_busy !== 1'b0) begin failures++; $display("FAIL hs_busy_clr got=%b exp=0", mod_busy); end
    checks++; if (mod_busy_cycles !== 32'd5) begin failures++; $display("FAIL hs_busy_cycles got=%0d exp=5", mod_busy_cycles); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    ap_start = 1'b1; ap_ready = 1'b0; cyc();
    checks++; if (mod_busy !== 1'b1 || mod_starts !== 32'd0)
      begin failures++; $display("FAIL b2b_no_ready got=%b/%0d exp=1/0", mod_busy, mod_starts); end
    ap_done = 1'b1; ap_continue = 1'b1; cyc();
    checks++; if (mod_busy !== 1'b0 || mod_dones !== 32'd1 || mod_busy_cycles !== 32'd1)
      begin failures++; $display("FAIL b2b_clear_wins got=%b/%0d/%0d exp=0/1/1", mod_busy, mod_dones, mod_busy_cycles); end
    ap_done = 1'b0; ap_continue = 1'b0; ap_start = 1'b0;
  endtask

  task automatic test_freeze();
    quit_at_end = 1'b0;
    pulse_reset();
    cur_state = C_PRE; cyc();
    cur_state = C_ITER; cyc();
    finish = 1'b1; cyc();
    finish = 1'b0;
    checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL frz_flag got=%b exp=1", frozen); end
    checks++; if (iter_started !== 32'd2 || iter_ended !== 32'd2 || loop_cycles !== 32'd1)
      begin failures++; $display("FAIL frz_last_cycle got=%0d/%0d/%0d exp=2/2/1", iter_started, iter_ended, loop_cycles); end
    cyc(3);
    cur_state = C_POST; ap_start = 1'b1; ap_ready = 1'b1; cyc();
    cur_state = C_OTH; ap_start = 1'b0; ap_ready = 1'b0; cyc();
    checks++; if (iter_started !== 32'd2 || iter_ended !== 32'd2 || loop_cycles !== 32'd1 || loop_invocations !== 32'd1)
      begin failures++; $display("FAIL frz_counters got=%0d/%0d/%0d/%0d exp=2/2/1/1", iter_started, iter_ended, loop_cycles, loop_invocations); end
    checks++; if (loop_state !== 2'd2 || mod_busy !== 1'b0 || mod_starts !== 32'd0 || frozen !== 1'b1)
      begin failures++; $display("FAIL frz_state got=%0d/%b/%0d/%b exp=2/0/0/1", loop_state, mod_busy, mod_starts, frozen); end
    pulse_reset();
    checks++; if (frozen !== 1'b0 || loop_state !== 2'd0 || iter_started !== 32'd0 || loop_cycles !== 32'd0 || loop_invocations !== 32'd0)
      begin failures++; $display("FAIL frz_reset got=%b/%0d/%0d/%0d/%0d exp=0", frozen, loop_state, iter_started, loop_cycles, loop_invocations); end
  endtask

  task automatic test_saturation();
    quit_at_end = 1'b0;
    pulse_reset();
    cur_state = C_PRE; cyc();
    cur_state = C_ITER; cyc(20);
    cur_state = C_POST; cyc();
    cur_state = C_OTH;
    checks++; if (s_started !== 4'd15) begin failures++; $display("FAIL sat_started got=%0d exp=15", s_started); end
    checks++; if (s_ended !== 4'd15 || s_loop_cycles !== 4'd15)
      begin failures++; $display("FAIL sat_ended_cycles got=%0d/%0d exp=15/15", s_ended, s_loop_cycles); end
    checks++; if (iter_started !== 32'd20) begin failures++; $display("FAIL wide_started got=%0d exp=20", iter_started); end
  endtask

  initial begin
    reset = 1'b0;
    quit_at_end = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_loop();
    test_stall();
    test_loop_err();
    test_handshake();
    test_back_to_back();
    test_freeze();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
